mvu_weight_sequencer: RTL and testbench

Streams a stored weight matrix into the `s_axis_weights` port of `mvu_vvu_axi`. Order is NF-outer, SF-inner, repeated once per input vector of a frame. Holds the matrix in an internal RAM written through a simple config port. Sequences RAM reads under AXI-Stream backpressure with credit-based issue and a small output FIFO, so full one-word-per-cycle throughput is sustained.

---
 rtl/mvu_seq_pkg.sv | 36 +++
 rtl/mvu_seq_fifo.sv | 53 +++++
 rtl/mvu_weight_sequencer.sv | 170 +++++++++++++++++
 tb/tb_mvu_weight_sequencer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mvu_seq_pkg.sv
// Shared types and size helpers for the MVU weight sequencer.
// Pure compile-time definitions; no timing or flow-control behaviour.
package mvu_seq_pkg;

  localparam int DEF_MW           = 120;
  localparam int DEF_MH           = 40;
  localparam int DEF_PE           = 10;
  localparam int DEF_SIMD         = 20;
  localparam int DEF_WEIGHT_WIDTH = 4;

  typedef logic [DEF_PE*DEF_SIMD*DEF_WEIGHT_WIDTH-1:0] weight_word_t;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  function automatic int calc_nf(input int mh, input int pe);
    return mh / pe;
  endfunction

  function automatic int calc_sf(input int mw, input int simd);
    return mw / simd;
  endfunction

  function automatic int calc_depth(input int mw, input int mh, input int pe, input int simd);
    return calc_nf(mh, pe) * calc_sf(mw, simd);
  endfunction

  function automatic int calc_ww_ba(input int ww);
    return (ww + 7) / 8 * 8;
  endfunction

  // Counter width that stays legal when the range collapses to one value.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mvu_seq_fifo.sv
// First-word-fall-through FIFO with occupancy count; o_pop_dat is valid whenever !o_empty.
// Zero read latency; the caller must never push when full or pop when empty.
module mvu_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_dat,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_dat,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_dat = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/mvu_weight_sequencer.sv
// Streams the stored weight matrix NF-outer/SF-inner, reps times; first beat 3 cycles after start.
// Reads issue only with FIFO credit, so tready backpressure never drops words and full rate is kept.
module mvu_weight_sequencer
  import mvu_seq_pkg::*;
#(
  parameter  int MW           = 120,
  parameter  int MH           = 40,
  parameter  int PE           = 10,
  parameter  int SIMD         = 20,
  parameter  int WEIGHT_WIDTH = 4,
  parameter  int REPS_WIDTH   = 16,
  localparam int NF           = calc_nf(MH, PE),
  localparam int SF           = calc_sf(MW, SIMD),
  localparam int DEPTH        = calc_depth(MW, MH, PE, SIMD),
  localparam int WW           = PE * SIMD * WEIGHT_WIDTH,
  localparam int WW_BA        = calc_ww_ba(WW),
  localparam int AW           = cnt_w(DEPTH)
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  cfg_wr_en,
  input  logic [AW-1:0]         cfg_wr_addr,
  input  logic [WW-1:0]         cfg_wr_data,
  output logic                  cfg_wr_rdy,
  input  logic                  start,
  input  logic [REPS_WIDTH-1:0] reps,
  output logic                  busy,
  output logic                  done,
  output logic [WW_BA-1:0]      m_axis_weights_tdata,
  output logic                  m_axis_weights_tvalid,
  input  logic                  m_axis_weights_tready,
  output logic                  m_axis_weights_tlast
);

  localparam int FIFO_D = 4;
  localparam int CW     = $clog2(FIFO_D + 1);
  localparam int SFW    = cnt_w(SF);
  localparam int NFW    = cnt_w(NF);

  state_t                r_state, w_state_nxt;
  logic                  r_done, w_done_nxt;
  logic [SFW-1:0]        r_sf;
  logic [NFW-1:0]        r_nf;
  logic [REPS_WIDTH-1:0] r_rep, r_reps, r_out_rep;
  logic [AW-1:0]         r_addr, r_out_idx;
  logic [WW-1:0]         r_mem [DEPTH];
  logic [WW-1:0]         r_rdata;
  logic                  r_pv;

  logic                  w_issue, w_pop, w_fifo_empty, w_cfg_we;
  logic                  w_mat_end, w_last_issue, w_start_run, w_final, w_tlast;
  logic [WW-1:0]         w_fifo_dat;
  logic [CW-1:0]         w_fifo_cnt;
  logic [CW:0]           w_occ;

  assign w_cfg_we     = cfg_wr_en && (r_state == S_IDLE) && ({1'b0, cfg_wr_addr} < (AW+1)'(DEPTH));
  assign w_start_run  = (r_state == S_IDLE) && start && (reps != '0);
  assign w_mat_end    = (r_sf == SFW'(SF - 1)) && (r_nf == NFW'(NF - 1));
  assign w_last_issue = w_mat_end && (r_rep == r_reps - 1'b1);

  // Occupancy the FIFO will hold after this edge, counting the word in the RAM output stage.
  assign w_occ   = (CW+1)'(w_fifo_cnt) + (CW+1)'(r_pv) - (CW+1)'(w_pop);
  assign w_issue = (r_state == S_RUN) && (w_occ < (CW+1)'(FIFO_D));

  assign w_pop   = !w_fifo_empty && m_axis_weights_tready;
  assign w_tlast = (r_out_idx == AW'(DEPTH - 1));
  assign w_final = (r_state == S_DRAIN) && w_pop && w_tlast && (r_out_rep == r_reps - 1'b1);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (reps != '0) w_state_nxt = S_RUN;
          else            w_done_nxt  = 1'b1;
        end
      end
      S_RUN:   if (w_issue && w_last_issue) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_final) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_sf      <= '0;
      r_nf      <= '0;
      r_rep     <= '0;
      r_reps    <= '0;
      r_addr    <= '0;
      r_pv      <= 1'b0;
      r_out_idx <= '0;
      r_out_rep <= '0;
    end else begin
      r_pv <= w_issue;
      if (w_start_run) begin
        r_reps <= reps;
        r_sf   <= '0;
        r_nf   <= '0;
        r_rep  <= '0;
        r_addr <= '0;
      end else if (w_issue) begin
        r_addr <= w_mat_end ? '0 : r_addr + 1'b1;
        if (r_sf == SFW'(SF - 1)) begin
          r_sf <= '0;
          if (r_nf == NFW'(NF - 1)) begin
            r_nf  <= '0;
            r_rep <= r_rep + 1'b1;
          end else begin
            r_nf <= r_nf + 1'b1;
          end
        end else begin
          r_sf <= r_sf + 1'b1;
        end
      end
      if (w_pop) begin
        if (w_tlast) begin
          r_out_idx <= '0;
          r_out_rep <= w_final ? '0 : r_out_rep + 1'b1;
        end else begin
          r_out_idx <= r_out_idx + 1'b1;
        end
      end
    end
  end

  // Weight RAM: contents survive reset; r_addr doubles as the read address register.
  always_ff @(posedge ap_clk) begin
    if (w_cfg_we) r_mem[cfg_wr_addr] <= cfg_wr_data;
    if (w_issue)  r_rdata <= r_mem[r_addr];
  end

  mvu_seq_fifo #(
    .DEPTH (FIFO_D),
    .WIDTH (WW)
  ) u_fifo (
    .i_clk      (ap_clk),
    .i_rst      (ap_rst),
    .i_push     (r_pv),
    .i_push_dat (r_rdata),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_dat),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_cnt)
  );

  assign m_axis_weights_tdata  = WW_BA'(w_fifo_dat);
  assign m_axis_weights_tvalid = !w_fifo_empty;
  assign m_axis_weights_tlast  = w_tlast;
  assign busy                  = (r_state != S_IDLE);
  assign cfg_wr_rdy            = (r_state == S_IDLE);
  assign done                  = r_done;

endmodule

// File: tb/tb_mvu_weight_sequencer.sv
// Bench for mvu_weight_sequencer: table of run scenarios, scoreboard of expected beats.
module tb_mvu_weight_sequencer;
  import mvu_seq_pkg::*;

  localparam int DEPTH = 24;
  localparam int AW    = 5;
  localparam int WW_BA = 800;
  localparam int RW    = 16;

  logic             ap_clk = 1'b0;
  logic             ap_rst;
  logic             cfg_wr_en;
  logic [AW-1:0]    cfg_wr_addr;
  weight_word_t     cfg_wr_data;
  logic             cfg_wr_rdy;
  logic             start;
  logic [RW-1:0]    reps;
  logic             busy;
  logic             done;
  logic [WW_BA-1:0] tdata;
  logic             tvalid;
  logic             tready;
  logic             tlast;

  mvu_weight_sequencer dut (
    .ap_clk                (ap_clk),
    .ap_rst                (ap_rst),
    .cfg_wr_en             (cfg_wr_en),
    .cfg_wr_addr           (cfg_wr_addr),
    .cfg_wr_data           (cfg_wr_data),
    .cfg_wr_rdy            (cfg_wr_rdy),
    .start                 (start),
    .reps                  (reps),
    .busy                  (busy),
    .done                  (done),
    .m_axis_weights_tdata  (tdata),
    .m_axis_weights_tvalid (tvalid),
    .m_axis_weights_tready (tready),
    .m_axis_weights_tlast  (tlast)
  );

  always #5 ap_clk = ~ap_clk;

  int checks = 0;
  int errors = 0;

  typedef struct { int w; bit l; } exp_t;
  exp_t sb[$];

  typedef struct {
    int reps;
    int pct;
    int stall_beat;
    int stall_len;
    bit disturb;
    int rst_beat;
    bit chain;
    int exp_beats;
    int exp_dones;
    int exp_lasts;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int n);
    for (int r = 0; r < n; r++)
      for (int i = 0; i < DEPTH; i++) sb.push_back('{i, (i == DEPTH - 1)});
  endtask

  task automatic do_run(input vec_t v, output int beats, output int dones, output int lasts);
    int cyc = 0, start_cyc = 0, base = 0, cur_total, first_vld = -1, last_hs = -1;
    int quiet = -1, stall_cnt = 0;
    bit chain_pend, disturbed = 0, rst_done = 0, prev_hold = 0, finished = 0;
    logic [31:0] prev_dat = '0;
    logic        prev_last = 1'b0;
    exp_t e;
    beats = 0; dones = 0; lasts = 0;
    chain_pend = v.chain;
    cur_total  = v.reps * DEPTH;
    push_exp(v.reps);
    start  = 1'b1;
    reps   = RW'(v.reps);
    tready = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      @(posedge ap_clk); #1;
      cyc++;
      start = 1'b0; cfg_wr_en = 1'b0; ap_rst = 1'b0;

      if (done) begin
        dones++;
        if (cur_total == 0) chk("done_latency_reps0", cyc - start_cyc, 1);
        else begin
          chk("done_after_last_beat", cyc - last_hs, 1);
          chk("done_beat_count", beats - base, cur_total);
        end
        chk("busy_at_done", busy, 0);
        chk("cfg_rdy_at_done", cfg_wr_rdy, 1);
        if (chain_pend) begin
          chain_pend = 0;
          push_exp(1);
          start = 1'b1; reps = RW'(1);
          start_cyc = cyc; cur_total = DEPTH; base = beats; first_vld = -1;
        end else if (quiet < 0) quiet = 4;
      end

      if (quiet >= 0) begin
        chk("idle_tvalid", tvalid, 0);
        chk("idle_busy", busy, 0);
        if (rst_done) chk("no_done_after_reset", done, 0);
        if (quiet == 0) begin finished = 1; break; end
        quiet--;
        continue;
      end

      if (cyc == start_cyc + 1) chk("busy_after_start", busy, (cur_total > 0) ? 1 : 0);
      if (tvalid && first_vld < 0) begin
        first_vld = cyc;
        chk("first_tvalid_latency", cyc - start_cyc, 3);
      end
      if (prev_hold) begin
        chk("hold_tvalid", tvalid, 1);
        chk("hold_tdata", tdata[31:0], prev_dat);
        chk("hold_tlast", tlast, prev_last);
      end

      if (v.rst_beat >= 0 && beats == v.rst_beat && !rst_done) begin
        ap_rst = 1'b1; tready = 1'b0; rst_done = 1; prev_hold = 0;
        sb.delete();
        quiet = 10;
        continue;
      end
      if (v.disturb && beats == 3 && !disturbed) begin
        disturbed   = 1;
        cfg_wr_en   = 1'b1;
        cfg_wr_addr = AW'(3);
        cfg_wr_data = weight_word_t'(8'hFF);
        start       = 1'b1;
        reps        = RW'(5);
        chk("cfg_rdy_while_busy", cfg_wr_rdy, 0);
      end
      if (beats == v.stall_beat && stall_cnt < v.stall_len) begin
        tready = 1'b0;
        stall_cnt++;
      end else begin
        tready = ($urandom_range(99) < v.pct);
      end

      if (tvalid && tready) begin
        if (sb.size() == 0) chk("scoreboard_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("beat_tdata", tdata[31:0], e.w);
          chk("beat_tdata_upper_zero", (tdata >> 32) != '0, 0);
          chk("beat_tlast", tlast, e.l);
        end
        if (tlast) lasts++;
        if (v.pct == 100 && v.stall_len == 0 && beats > base) chk("beat_gap", cyc - last_hs, 1);
        beats++;
        last_hs = cyc;
      end
      prev_hold = tvalid && !tready;
      prev_dat  = tdata[31:0];
      prev_last = tlast;
    end
    if (!finished) chk("run_timeout", 0, 1);
    chk("scoreboard_empty", sb.size(), 0);
    sb.delete();
    start = 1'b0; tready = 1'b0; cfg_wr_en = 1'b0; ap_rst = 1'b0;
  endtask

  initial begin
    int b, d, l;
    //        reps pct stall_b len dist rst  chain beats dones lasts
    vecs[0] = '{1, 100, -1,  0, 0, -1, 0, 24, 1, 1};
    vecs[1] = '{3,  70, -1,  0, 0, -1, 0, 72, 1, 3};
    vecs[2] = '{0, 100, -1,  0, 0, -1, 0,  0, 1, 0};
    vecs[3] = '{1, 100,  5, 20, 0, -1, 0, 24, 1, 1};
    vecs[4] = '{1, 100, -1,  0, 1, -1, 0, 24, 1, 1};
    vecs[5] = '{1, 100, -1,  0, 0, 10, 0, 10, 0, 0};
    vecs[6] = '{1, 100, -1,  0, 0, -1, 0, 24, 1, 1};
    vecs[7] = '{0, 100, -1,  0, 0, -1, 1, 24, 2, 1};
    vecs[8] = '{2,  40, -1,  0, 0, -1, 0, 48, 1, 2};

    ap_rst = 1'b1; cfg_wr_en = 1'b0; cfg_wr_addr = '0; cfg_wr_data = '0;
    start = 1'b0; reps = '0; tready = 1'b0;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("reset_tvalid", tvalid, 0);
    chk("reset_tlast", tlast, 0);
    chk("reset_done", done, 0);
    chk("reset_busy", busy, 0);
    chk("reset_cfg_rdy", cfg_wr_rdy, 1);
    ap_rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) begin
      cfg_wr_en = 1'b1; cfg_wr_addr = AW'(i); cfg_wr_data = weight_word_t'(i);
      @(posedge ap_clk); #1;
    end
    cfg_wr_en = 1'b1; cfg_wr_addr = AW'(DEPTH + 2); cfg_wr_data = weight_word_t'(8'hAA);
    @(posedge ap_clk); #1;
    cfg_wr_en = 1'b0;

    for (int k = 0; k < 9; k++) begin
      do_run(vecs[k], b, d, l);
      chk($sformatf("vec%0d_beats", k), b, vecs[k].exp_beats);
      chk($sformatf("vec%0d_dones", k), d, vecs[k].exp_dones);
      chk($sformatf("vec%0d_tlasts", k), l, vecs[k].exp_lasts);
      repeat (2) @(posedge ap_clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
